cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle memory-to-memory CPU with three-operand instructions.
// The memory address is registered inside the CPU. The memory returns mem for that
// address in the following cycle, and a write completes on the clock edge that ends WB.
// Operands may be direct (mem[A]) or indirect (mem[mem[A]]).
// Arithmetic-class ops (MOV/ADD/SUB/MUL/DIV) read both source operands y and z.
// OUT reads only operand x.
// Optional feature macro CPU_DIV_EN: when defined, opcode 0100 executes DIV;
// otherwise it is treated as an illegal opcode and no divider is built.
module cpu_multicycle #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int PC_START   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] mem,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic                  halted,
   output logic                  error
);

   localparam logic [3:0] OP_MOV  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_DIV  = 4'h4;
   localparam logic [3:0] OP_IN   = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_LDI  = 4'h9;
   localparam logic [3:0] OP_STOP = 4'hF;

   typedef enum logic [3:0] {
      FETCH_A, FETCH_W, DECODE, IMM_A, IMM_W, OP_A, OP_W, IND_A, IND_W,
      EXEC, IN_WAIT, WB_PTR_A, WB_PTR_W, WB, HALT
   } state_t;

   state_t state_reg, state_next;

   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  we_reg;
   logic                  in_ready_reg;
   logic [DATA_WIDTH-1:0] out_reg;
   logic                  out_valid_reg;
   logic                  halted_reg;
   logic                  error_reg;
   logic [15:0]           ir_reg;
   logic [1:0]            opn_reg;      // operand being read: 0 = x, 1 = y, 2 = z
   logic [ADDR_WIDTH-1:0] ptr_reg;      // pointer captured for indirect operand reads
   logic [DATA_WIDTH-1:0] y_reg;        // first source operand (also x for OUT)
   logic [DATA_WIDTH-1:0] z_reg;        // second source operand
   logic [DATA_WIDTH-1:0] result_reg;   // value waiting for write-back

   // Instruction fields
   logic [3:0] opcode;
   logic       ind1, ind2, ind3;
   logic [2:0] a1, a2, a3;

   assign opcode = ir_reg[15:12];
   assign ind1   = ir_reg[11];
   assign a1     = ir_reg[10:8];
   assign ind2   = ir_reg[7];
   assign a2     = ir_reg[6:4];
   assign ind3   = ir_reg[3];
   assign a3     = ir_reg[2:0];

   logic                  cur_ind;
   logic [2:0]            cur_a;
   logic                  last_operand;
   logic                  op_legal;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [DATA_WIDTH-1:0] wb_value;
   logic [ADDR_WIDTH-1:0] mem_ptr;

   assign mem_ptr      = mem[ADDR_WIDTH-1:0];
   assign last_operand = (opn_reg != 2'd1);

   assign we        = we_reg;
   assign addr      = addr_reg;
   assign data      = data_reg;
   assign in_ready  = in_ready_reg;
   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign pc        = pc_reg;
   assign sp        = '1;
   assign halted    = halted_reg;
   assign error     = error_reg;

   // Select the addressing bit and address field of the operand currently being read
   always_comb begin
      cur_ind = ind2;
      cur_a   = a2;
      case (opn_reg)
         2'd0:    begin cur_ind = ind1; cur_a = a1; end
         2'd2:    begin cur_ind = ind3; cur_a = a3; end
         default: begin cur_ind = ind2; cur_a = a2; end
      endcase
   end

   // Opcode legality; DIV is legal only when the divider is built
   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_MOV, OP_ADD, OP_SUB, OP_MUL,
         OP_IN, OP_OUT, OP_LDI, OP_STOP: op_legal = 1'b1;
`ifdef CPU_DIV_EN
         OP_DIV:                         op_legal = 1'b1;
`endif
         default:                        op_legal = 1'b0;
      endcase
   end

   // Unsigned arithmetic modulo 2^DATA_WIDTH on the two source operands
   always_comb begin
      alu_result = y_reg;
      case (opcode)
         OP_ADD:  alu_result = y_reg + z_reg;
         OP_SUB:  alu_result = y_reg - z_reg;
         OP_MUL:  alu_result = y_reg * z_reg;
`ifdef CPU_DIV_EN
         OP_DIV:  alu_result = (z_reg == '0) ? '1 : (y_reg / z_reg);
`endif
         default: alu_result = y_reg;
      endcase
   end

   // Value headed for write-back, taken from whichever state produces it
   always_comb begin
      wb_value = result_reg;
      case (state_reg)
         EXEC:    wb_value = alu_result;
         IMM_W:   wb_value = mem;
         IN_WAIT: wb_value = in;
         default: wb_value = result_reg;
      endcase
   end

   // State register; asynchronous reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= FETCH_A;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FETCH_A: state_next = FETCH_W;
         FETCH_W: state_next = DECODE;
         DECODE: begin
            if (!op_legal || opcode == OP_STOP) state_next = HALT;
            else if (opcode == OP_LDI)          state_next = IMM_A;
            else if (opcode == OP_IN)           state_next = IN_WAIT;
            else                                state_next = OP_A;
         end
         IMM_A:   state_next = IMM_W;
         IMM_W:   state_next = ind1 ? WB_PTR_A : WB;
         IN_WAIT: begin
            if (in_valid) state_next = ind1 ? WB_PTR_A : WB;
         end
         OP_A:    state_next = OP_W;
         OP_W: begin
            if (cur_ind)           state_next = IND_A;
            else if (last_operand) state_next = EXEC;
            else                   state_next = OP_A;
         end
         IND_A:   state_next = IND_W;
         IND_W:   state_next = last_operand ? EXEC : OP_A;
         EXEC: begin
            if (opcode == OP_OUT) state_next = FETCH_A;
            else                  state_next = ind1 ? WB_PTR_A : WB;
         end
         WB_PTR_A: state_next = WB_PTR_W;
         WB_PTR_W: state_next = WB;
         WB:       state_next = FETCH_A;
         HALT:     state_next = HALT;
         default:  state_next = HALT;
      endcase
   end

   // Datapath: PC, memory bus registers, operand capture and I/O
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg        <= ADDR_WIDTH'(PC_START);
         addr_reg      <= '0;
         data_reg      <= '0;
         we_reg        <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         halted_reg    <= 1'b0;
         error_reg     <= 1'b0;
         ir_reg        <= '0;
         opn_reg       <= 2'd1;
         ptr_reg       <= '0;
         y_reg         <= '0;
         z_reg         <= '0;
         result_reg    <= '0;
      end else begin
         we_reg        <= (state_next == WB);
         in_ready_reg  <= (state_next == IN_WAIT);
         out_valid_reg <= 1'b0;
         if (state_next == HALT) halted_reg <= 1'b1;

         case (state_reg)
            FETCH_A: begin
               addr_reg <= pc_reg;
               pc_reg   <= pc_reg + 1'b1;
            end
            FETCH_W: ir_reg <= mem[15:0];
            DECODE: begin
               opn_reg <= (opcode == OP_OUT) ? 2'd0 : 2'd1;
               if (!op_legal) error_reg <= 1'b1;
            end
            IMM_A: begin
               addr_reg <= pc_reg;
               pc_reg   <= pc_reg + 1'b1;
            end
            IMM_W:   result_reg <= wb_value;
            IN_WAIT: result_reg <= wb_value;
            OP_A:    addr_reg <= ADDR_WIDTH'(cur_a);
            OP_W: begin
               ptr_reg <= mem_ptr;
               if (!cur_ind) begin
                  if (opn_reg == 2'd2) z_reg <= mem;
                  else                 y_reg <= mem;
                  opn_reg <= 2'd2;
               end
            end
            IND_A:   addr_reg <= ptr_reg;
            IND_W: begin
               if (opn_reg == 2'd2) z_reg <= mem;
               else                 y_reg <= mem;
               opn_reg <= 2'd2;
            end
            EXEC: begin
               result_reg <= wb_value;
               if (opcode == OP_OUT) begin
                  out_reg       <= y_reg;
                  out_valid_reg <= 1'b1;
               end
            end
            WB_PTR_A: addr_reg <= ADDR_WIDTH'(a1);
            default: ;
         endcase

         // Present the write for the single WB cycle
         if (state_next == WB) begin
            data_reg <= wb_value;
            addr_reg <= (state_reg == WB_PTR_W) ? mem_ptr : ADDR_WIDTH'(a1);
         end
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: randomized and directed programs checked against an
// instruction-level reference interpreter with per-instruction cycle costs.
module tb_cpu_multicycle;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int PCS = 8;
   localparam int LIMIT = 80;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] mem;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic [DW-1:0] in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out;
   logic          out_valid;
   logic [AW-1:0] pc;
   logic [AW-1:0] sp;
   logic          halted;
   logic          error;

   cpu_multicycle #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_START(PCS)) dut (
      .clk(clk), .rst_n(rst_n), .mem(mem), .we(we), .addr(addr), .data(data),
      .in(in), .in_valid(in_valid), .in_ready(in_ready), .out(out),
      .out_valid(out_valid), .pc(pc), .sp(sp), .halted(halted), .error(error)
   );

   always #5 clk = ~clk;

   // Memory: address registered in the CPU, read data follows addr, write on the edge
   logic [15:0] ram [64];
   assign mem = ram[addr];
   always @(posedge clk) if (we) ram[addr] = data;

   typedef struct { int c; int a; int d; } ev_t;
   typedef struct { int dly; int val; } inp_t;

   ev_t  got_w[$], exp_w[$], got_o[$], exp_o[$];
   inp_t drv_q[$], mdl_q[$], in_list[$];
   logic [15:0] img [64];
   logic [15:0] mm [64];
   int cyc, rdy_cnt, wcnt, tm_g;
   int total = 0;
   int bad = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: cycle n after reset release is sampled at the n-th falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         cyc = 0; rdy_cnt = 0;
         got_w.delete(); got_o.delete();
      end else begin
         cyc++;
         if (we) got_w.push_back('{cyc, int'(addr), int'(data)});
         if (out_valid) got_o.push_back('{cyc, 0, int'(out)});
         if (in_ready) rdy_cnt++;
      end
   end

   // Input source: holds in_valid low for dly cycles of in_ready, then offers val
   always @(negedge clk) begin
      if (!rst_n) begin
         in_valid = 1'b0; wcnt = 0;
      end else begin
         if (in_valid && !in_ready) begin
            if (drv_q.size() > 0) void'(drv_q.pop_front());
            wcnt = 0;
         end
         in_valid = 1'b0;
         if (in_ready && drv_q.size() > 0) begin
            if (wcnt == drv_q[0].dly) begin
               in_valid = 1'b1;
               in = DW'(drv_q[0].val);
            end else begin
               wcnt++;
            end
         end
      end
   end

   function automatic logic [15:0] rdop(logic ind, logic [2:0] a);
      logic [15:0] p;
      p = mm[a];
      tm_g += ind ? 4 : 2;
      return ind ? mm[p[5:0]] : p;
   endfunction

   // Reference interpreter: executes instructions on mm, logs writes/outputs with cycle numbers
   task automatic model(output int t_end, output bit hlt, output bit er, output int pce);
      int pcm, c;
      logic [15:0] ir, y, z, v, p;
      logic [3:0] op;
      bit do_wb;
      inp_t ip;
      int wa;
      pcm = PCS; c = 0; hlt = 0; er = 0;
      for (int n = 0; n < LIMIT && !hlt; n++) begin
         ir = mm[pcm]; pcm = (pcm + 1) % 64; tm_g = 3; op = ir[15:12]; do_wb = 0; v = 0;
         case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
               y = rdop(ir[7], ir[6:4]); z = rdop(ir[3], ir[2:0]); tm_g += 1; do_wb = 1;
               v = (op == 4'h0) ? y : (op == 4'h1) ? y + z : (op == 4'h2) ? y - z : y * z;
            end
`ifdef CPU_DIV_EN
            4'h4: begin
               y = rdop(ir[7], ir[6:4]); z = rdop(ir[3], ir[2:0]); tm_g += 1; do_wb = 1;
               v = (z == 0) ? 16'hFFFF : y / z;
            end
`endif
            4'h7: begin
               if (mdl_q.size() == 0) break;
               ip = mdl_q.pop_front();
               tm_g += ip.dly + 1; v = 16'(ip.val); do_wb = 1;
            end
            4'h8: begin
               y = rdop(ir[11], ir[10:8]); tm_g += 1;
               exp_o.push_back('{c + tm_g + 1, 0, int'(y)});
            end
            4'h9: begin
               v = mm[pcm]; pcm = (pcm + 1) % 64; tm_g += 2; do_wb = 1;
            end
            4'hF: hlt = 1;
            default: begin hlt = 1; er = 1; end
         endcase
         if (do_wb) begin
            tm_g += ir[11] ? 3 : 1;
            p = mm[ir[10:8]];
            wa = ir[11] ? int'(p[5:0]) : int'(ir[10:8]);
            exp_w.push_back('{c + tm_g, wa, int'(v)});
            mm[wa] = v;
         end
         c += tm_g;
      end
      t_end = c; pce = pcm;
   endtask

   task automatic start_dut();
      rst_n = 1'b0;
      ram = img;
      drv_q = in_list;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic run_prog(string name);
      int t_end, pce, nw, no;
      bit hlt, er;
      mm = img; exp_w.delete(); exp_o.delete(); mdl_q = in_list;
      model(t_end, hlt, er, pce);
      start_dut();
      while (cyc < t_end + 2) begin @(negedge clk); #1; end
      chk({name, ".nwrites"}, got_w.size(), exp_w.size());
      nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
      for (int i = 0; i < nw; i++) begin
         chk({name, ".waddr"}, got_w[i].a, exp_w[i].a);
         chk({name, ".wdata"}, got_w[i].d, exp_w[i].d);
         chk({name, ".wcyc"}, got_w[i].c, exp_w[i].c);
      end
      chk({name, ".nouts"}, got_o.size(), exp_o.size());
      no = (got_o.size() < exp_o.size()) ? got_o.size() : exp_o.size();
      for (int i = 0; i < no; i++) begin
         chk({name, ".outval"}, got_o[i].d, exp_o[i].d);
         chk({name, ".outcyc"}, got_o[i].c, exp_o[i].c);
      end
      chk({name, ".halted"}, halted, hlt);
      chk({name, ".error"}, error, er);
      if (hlt) chk({name, ".pc"}, pc, pce);
      $display("prog %s: cycles=%0d writes=%0d outs=%0d halted=%0d error=%0d",
               name, t_end, exp_w.size(), exp_o.size(), hlt, er);
   endtask

   task automatic clear_img();
      for (int i = 0; i < 64; i++) img[i] = 16'h0000;
      in_list.delete();
   endtask

   task automatic rand_img();
      int p, r;
      logic [3:0] op;
      clear_img();
      for (int i = 0; i < 8; i++) img[i] = 16'($urandom_range(32, 63));
      for (int i = 32; i < 64; i++) img[i] = 16'($urandom);
      for (int i = 0; i < LIMIT; i++) in_list.push_back('{$urandom_range(0, 3), $urandom_range(0, 65535)});
      p = PCS;
      while (p < 30) begin
         r = $urandom_range(0, 19);
         if (r == 4) op = 4'h4;
         else if (r < 7) op = (r < 4) ? 4'(r) : 4'h8;
         else if (r < 9) op = 4'h9;
         else if (r == 9) op = 4'h7;
         else if (r == 10) op = 4'h5;
         else op = 4'($urandom_range(0, 3));
         img[p] = {op, 12'($urandom)};
         p++;
         if (op == 4'h9) begin img[p] = 16'($urandom); p++; end
      end
      img[p] = 16'hF000;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      // Reset state
      #12;
      chk("rst.we", we, 0);        chk("rst.addr", addr, 0);
      chk("rst.data", data, 0);    chk("rst.pc", pc, PCS);
      chk("rst.sp", sp, 6'h3F);    chk("rst.out", out, 0);
      chk("rst.out_valid", out_valid, 0); chk("rst.in_ready", in_ready, 0);
      chk("rst.halted", halted, 0); chk("rst.error", error, 0);

      // Direct ADD: mem[1] = 7 + 3 written in cycle 9
      clear_img();
      img[1] = 16'd5; img[2] = 16'd7; img[3] = 16'd3; img[8] = 16'h1123; img[9] = 16'hF000;
      run_prog("add");
      chk("add.mem1", ram[1], 16'd10);
      chk("add.wcyc9", (got_w.size() > 0) ? got_w[0].c : -1, 9);

      // Indirect-source MOV takes 11 cycles
      clear_img();
      img[4] = 16'd20; img[20] = 16'hABCD; img[8] = 16'h05C0; img[9] = 16'hF000;
      run_prog("movind");
      chk("movind.mem5", ram[5], 16'hABCD);
      chk("movind.wcyc11", (got_w.size() > 0) ? got_w[0].c : -1, 11);

      // IN with 5 idle cycles, then OUT of the stored value
      clear_img();
      img[8] = 16'h7600; img[9] = 16'h8600; img[10] = 16'hF000;
      in_list.push_back('{5, 16'h1234});
      run_prog("inout");
      chk("inout.ready_cycles", rdy_cnt, 6);
      chk("inout.mem6", ram[6], 16'h1234);
      chk("inout.out", out, 16'h1234);

      // LDI then STOP
      clear_img();
      img[8] = 16'h9700; img[9] = 16'h00FF; img[10] = 16'hF000;
      run_prog("ldi");
      chk("ldi.mem7", ram[7], 16'h00FF);
      chk("ldi.pc", pc, 11);
      chk("ldi.halted", halted, 1);
      chk("ldi.error", error, 0);

      // DIV by zero
      clear_img();
      img[1] = 16'd9; img[2] = 16'd0; img[8] = 16'h4112; img[9] = 16'hF000;
      run_prog("div0");
`ifdef CPU_DIV_EN
      chk("div0.mem1", ram[1], 16'hFFFF);
      chk("div0.error", error, 0);
`else
      chk("div0.halted", halted, 1);
      chk("div0.error", error, 1);
      chk("div0.nowrite", ram[1], 16'd9);
`endif

      // PC wraps from 63 to 0 (MOV 0<-0 everywhere, STOP at address 1)
      clear_img();
      img[1] = 16'hF000;
      run_prog("wrap");
      chk("wrap.pc", pc, 2);

      // Reset during WB of an ADD aborts the write
      clear_img();
      img[1] = 16'd5; img[2] = 16'd7; img[3] = 16'd3; img[8] = 16'h1123; img[9] = 16'hF000;
      start_dut();
      guard = 0;
      while (cyc < 9 && guard < 100) begin @(negedge clk); #1; guard++; end
      chk("rstwb.reach", guard < 100, 1);
      chk("rstwb.we_before", we, 1);
      rst_n = 1'b0; #1;
      chk("rstwb.we", we, 0);       chk("rstwb.addr", addr, 0);
      chk("rstwb.data", data, 0);   chk("rstwb.pc", pc, PCS);
      chk("rstwb.sp", sp, 6'h3F);   chk("rstwb.out_valid", out_valid, 0);
      chk("rstwb.halted", halted, 0); chk("rstwb.error", error, 0);
      @(posedge clk); #1;
      chk("rstwb.mem1", ram[1], 16'd5);
      rst_n = 1'b1; #1;
      chk("rstwb.pc_rel", pc, PCS);
      chk("rstwb.addr_rel", addr, 0);
      @(posedge clk); #1;
      chk("rstwb.fetch_addr", addr, PCS);
      chk("rstwb.fetch_pc", pc, PCS + 1);
      $display("prog rstwb: write aborted mem1=%0d", ram[1]);

      // Randomized programs
      for (int k = 0; k < 20; k++) begin
         rand_img();
         run_prog($sformatf("rand%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
